// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 full-protocol bundle between the DMA master port and axi_burst_mem_slave.
// The master modport drives requests and write data; the slave modport answers.
interface axi_burst_mem_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int ID_W   = 1,
    parameter int LEN_W  = 8
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [LEN_W-1:0]    awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [LEN_W-1:0]    arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_burst_mem_slave.sv
// AXI4 INCR-burst responder backed by a single-port synchronous RAM, one transaction at a time.
// Define AXI_SLV_LAST_CHK_EN to check wlast against the beat count and answer SLVERR on mismatch.
module axi_burst_mem_slave #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 256,
    parameter int ID_W       = 1,
    parameter int LEN_W      = 8,
    parameter int MEM_ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_burst_mem_slave_if.slave s_axi
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int DEPTH  = 1 << MEM_ADDR_W;

    typedef enum logic [2:0] {IDLE, W_DATA, W_RESP, R_ADDR, R_DATA} state_t;

    state_t                state, state_d;
    logic [MEM_ADDR_W-1:0] idx, idx_d;
    logic [LEN_W:0]        cnt, cnt_d;
    logic [ID_W-1:0]       id_q, id_d;
    // Set: the write channel wins the next AW/AR collision.
    logic                  ptr_w, ptr_w_d;

    logic                  grant_w, grant_r, last_beat;
    logic                  mem_we, rd_en;
    logic [MEM_ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     rdata_q;

`ifdef AXI_SLV_LAST_CHK_EN
    logic                  err, err_d;
`endif

    // Fields that carry no meaning for a fixed INCR full-width responder.
    logic                  unused_sig;
`ifdef AXI_SLV_LAST_CHK_EN
    assign unused_sig = &{1'b0, s_axi.awsize, s_axi.awburst, s_axi.arsize, s_axi.arburst,
                          s_axi.awaddr, s_axi.araddr};
`else
    assign unused_sig = &{1'b0, s_axi.awsize, s_axi.awburst, s_axi.arsize, s_axi.arburst,
                          s_axi.awaddr, s_axi.araddr, s_axi.wlast};
`endif

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        id_d    = id_q;
        ptr_w_d = ptr_w;
        mem_we  = 1'b0;
        rd_en   = 1'b0;
        rd_idx  = idx;
`ifdef AXI_SLV_LAST_CHK_EN
        err_d   = err;
`endif
        s_axi.awready = 1'b0;
        s_axi.arready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.bresp   = 2'b00;
        s_axi.rvalid  = 1'b0;
        s_axi.rlast   = 1'b0;

        last_beat = (cnt == (LEN_W+1)'(1));
        grant_w   = rst_n && s_axi.awvalid && (!s_axi.arvalid || ptr_w);
        grant_r   = rst_n && s_axi.arvalid && !grant_w;

        case (state)
            IDLE: begin
                s_axi.awready = grant_w;
                s_axi.arready = grant_r;
                if (grant_w) begin
                    id_d    = s_axi.awid;
                    idx_d   = s_axi.awaddr[MEM_ADDR_W+OFF_W-1:OFF_W];
                    cnt_d   = {1'b0, s_axi.awlen} + (LEN_W+1)'(1);
                    ptr_w_d = 1'b0;
                    state_d = W_DATA;
                end else if (grant_r) begin
                    id_d    = s_axi.arid;
                    idx_d   = s_axi.araddr[MEM_ADDR_W+OFF_W-1:OFF_W];
                    cnt_d   = {1'b0, s_axi.arlen} + (LEN_W+1)'(1);
                    ptr_w_d = 1'b1;
                    state_d = R_ADDR;
                end
            end
            W_DATA: begin
                s_axi.wready = 1'b1;
                if (s_axi.wvalid) begin
                    mem_we = 1'b1;
                    idx_d  = idx + MEM_ADDR_W'(1);
                    cnt_d  = cnt - (LEN_W+1)'(1);
`ifdef AXI_SLV_LAST_CHK_EN
                    if (s_axi.wlast != last_beat) err_d = 1'b1;
`endif
                    if (last_beat) state_d = W_RESP;
                end
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
`ifdef AXI_SLV_LAST_CHK_EN
                if (err) s_axi.bresp = 2'b10;
`endif
                if (s_axi.bready) begin
`ifdef AXI_SLV_LAST_CHK_EN
                    err_d = 1'b0;
`endif
                    state_d = IDLE;
                end
            end
            R_ADDR: begin
                rd_en   = 1'b1;
                state_d = R_DATA;
            end
            R_DATA: begin
                s_axi.rvalid = 1'b1;
                s_axi.rlast  = last_beat;
                rd_en        = 1'b1;
                // Prefetch the next word on acceptance so beats can stream every cycle.
                if (s_axi.rready) begin
                    rd_idx = idx + MEM_ADDR_W'(1);
                    idx_d  = idx + MEM_ADDR_W'(1);
                    cnt_d  = cnt - (LEN_W+1)'(1);
                    if (last_beat) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            id_q  <= '0;
            ptr_w <= 1'b1;
`ifdef AXI_SLV_LAST_CHK_EN
            err   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            idx   <= idx_d;
            cnt   <= cnt_d;
            id_q  <= id_d;
            ptr_w <= ptr_w_d;
`ifdef AXI_SLV_LAST_CHK_EN
            err   <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.wstrb[b]) mem[idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[rd_idx];
    end

    assign s_axi.rdata = rdata_q;
    assign s_axi.rid   = id_q;
    assign s_axi.bid   = id_q;
    assign s_axi.rresp = 2'b00;
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed bench for axi_burst_mem_slave: bursts, stalls, arbitration, index wrap, strobes, wlast check.
module tb_axi_burst_mem_slave;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 256;
    localparam int ID_W       = 1;
    localparam int LEN_W      = 8;
    localparam int MEM_ADDR_W = 11;

`ifdef AXI_SLV_LAST_CHK_EN
    localparam logic [1:0] LAST_ERR_RESP = 2'b10;
`else
    localparam logic [1:0] LAST_ERR_RESP = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [DATA_W-1:0] wbuf [8];
    logic [DATA_W-1:0] rbuf [8];
    logic [DATA_W-1:0] mix;

    axi_burst_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) s_axi ();

    axi_burst_mem_slave #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W), .MEM_ADDR_W(MEM_ADDR_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axi (s_axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int s);
        logic [DATA_W-1:0] v;
        for (int k = 0; k < DATA_W/32; k++) v[k*32 +: 32] = 32'(s) * 32'h9E37_79B9 + 32'(k) + 32'h0101_0000;
        return v;
    endfunction

    task automatic do_write(input string tag, input logic [ID_W-1:0] id, input logic [31:0] addr,
                            input int len, input int last_at, input logic [DATA_W/8-1:0] strb,
                            input logic [1:0] exp_resp, input bit contend);
        int n;
        @(posedge clk); #1;
        s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = LEN_W'(len); s_axi.awvalid = 1'b1;
        s_axi.araddr = 32'h0; s_axi.arlen = '0; s_axi.arvalid = contend;
        n = 0;
        @(negedge clk);
        while (!s_axi.awready && n < 16) begin @(negedge clk); n++; end
        chk({tag, "_awready"}, s_axi.awready, 1);
        if (contend) chk({tag, "_arready"}, s_axi.arready, 0);
        @(posedge clk); #1;
        s_axi.awvalid = 1'b0; s_axi.arvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            s_axi.wdata = wbuf[b]; s_axi.wstrb = strb; s_axi.wlast = (b == last_at); s_axi.wvalid = 1'b1;
            @(negedge clk);
            chk({tag, "_wready"}, s_axi.wready, 1);
            @(posedge clk); #1;
        end
        s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
        @(negedge clk);
        chk({tag, "_wready_drop"}, s_axi.wready, 0);
        chk({tag, "_bvalid"}, s_axi.bvalid, 1);
        chk({tag, "_bresp"}, s_axi.bresp, exp_resp);
        chk({tag, "_bid"}, s_axi.bid, id);
        @(negedge clk);
        chk({tag, "_bvalid_hold"}, s_axi.bvalid, 1);
        @(posedge clk); #1;
        s_axi.bready = 1'b1;
        @(posedge clk); #1;
        s_axi.bready = 1'b0;
        @(negedge clk);
        chk({tag, "_bvalid_done"}, s_axi.bvalid, 0);
    endtask

    task automatic do_read(input string tag, input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input int len, input bit stall, input bit contend);
        int n, c, beat;
        bit held;
        logic [DATA_W-1:0] hdata;
        @(posedge clk); #1;
        s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = LEN_W'(len); s_axi.arvalid = 1'b1;
        s_axi.awaddr = 32'h0; s_axi.awlen = '0; s_axi.awvalid = contend;
        n = 0;
        @(negedge clk);
        while (!s_axi.arready && n < 16) begin @(negedge clk); n++; end
        chk({tag, "_arready"}, s_axi.arready, 1);
        if (contend) chk({tag, "_awready"}, s_axi.awready, 0);
        @(posedge clk); #1;
        s_axi.arvalid = 1'b0; s_axi.awvalid = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid_early"}, s_axi.rvalid, 0);
        c = 0; beat = 0; held = 1'b0; hdata = '0;
        while (beat <= len && c < 64) begin
            @(posedge clk); #1;
            s_axi.rready = !stall || (c % 3 == 0);
            @(negedge clk);
            if (c == 0) chk({tag, "_rvalid_lat"}, s_axi.rvalid, 1);
            if (s_axi.rvalid) begin
                if (held) chk({tag, "_stable"}, s_axi.rdata, hdata);
                if (s_axi.rready) begin
                    chk({tag, $sformatf("_data%0d", beat)}, s_axi.rdata, rbuf[beat]);
                    chk({tag, $sformatf("_rlast%0d", beat)}, s_axi.rlast, beat == len);
                    chk({tag, "_rid"}, s_axi.rid, id);
                    chk({tag, "_rresp"}, s_axi.rresp, 2'b00);
                    beat++;
                    held = 1'b0;
                end else begin
                    held  = 1'b1;
                    hdata = s_axi.rdata;
                end
            end
            c++;
        end
        chk({tag, "_beats"}, beat, len + 1);
        @(posedge clk); #1;
        s_axi.rready = 1'b0;
        @(negedge clk);
        chk({tag, "_rvalid_done"}, s_axi.rvalid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = 3'd5; s_axi.awburst = 2'b01;
        s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b0;
        s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arsize = 3'd5; s_axi.arburst = 2'b01;
        s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", s_axi.awready, 0);
        chk("rst_arready", s_axi.arready, 0);
        chk("rst_wready",  s_axi.wready, 0);
        chk("rst_bvalid",  s_axi.bvalid, 0);
        chk("rst_rvalid",  s_axi.rvalid, 0);
        chk("rst_rlast",   s_axi.rlast, 0);
        chk("rst_rdata",   s_axi.rdata, '0);
        chk("rst_bresp",   s_axi.bresp, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Four-beat burst into words 8..11, then read back streaming and with stalls.
        for (int i = 0; i < 4; i++) begin wbuf[i] = pat(i); rbuf[i] = pat(i); end
        do_write("w_burst", 1'b1, 32'h100, 3, 3, '1, 2'b00, 1'b0);
        do_read("r_stream", 1'b0, 32'h100, 3, 1'b0, 1'b0);
        do_read("r_stall", 1'b1, 32'h100, 3, 1'b1, 1'b0);

        // Collisions: write wins first, read second; the write/read also wrap past word 2047.
        wbuf[0] = pat(10); wbuf[1] = pat(11);
        rbuf[0] = pat(10); rbuf[1] = pat(11);
        do_write("w_contend", 1'b0, 32'hFFE0, 1, 1, '1, 2'b00, 1'b1);
        do_read("r_contend", 1'b1, 32'hFFE0, 1, 1'b0, 1'b1);
        rbuf[0] = pat(11);
        do_read("r_word0", 1'b0, 32'h0, 0, 1'b0, 1'b0);

        // Partial strobe keeps the upper half of the earlier word.
        wbuf[0] = pat(20);
        do_write("w_full", 1'b0, 32'h280, 0, 0, '1, 2'b00, 1'b0);
        wbuf[0] = pat(21);
        do_write("w_strb", 1'b1, 32'h280, 0, 0, 32'h0000_FFFF, 2'b00, 1'b0);
        mix = pat(20);
        mix[127:0] = wbuf[0][127:0];
        rbuf[0] = mix;
        do_read("r_strb", 1'b1, 32'h280, 0, 1'b0, 1'b0);

        // Early wlast: all three beats still land; response depends on the build.
        for (int i = 0; i < 3; i++) begin wbuf[i] = pat(30 + i); rbuf[i] = pat(30 + i); end
        do_write("w_early_last", 1'b1, 32'h400, 2, 1, '1, LAST_ERR_RESP, 1'b0);
        do_read("r_early_last", 1'b0, 32'h400, 2, 1'b0, 1'b0);
        wbuf[0] = pat(40);
        do_write("w_after_err", 1'b0, 32'h500, 0, 0, '1, 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
